// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 8-bit ALU between NREQ requesters.
// Registers operands into the ALU, then returns the registered result and flags to the winner.
package alu_arbiter_pkg;
  localparam int unsigned DW           = 8;
  localparam int unsigned IDW          = 3;
  localparam int unsigned FLAG_UNKNOWN = 5;

  typedef struct packed {
    logic [DW-1:0] op;
    logic [DW-1:0] b;
    logic [DW-1:0] a;
  } alu_req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;
endpackage

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [8*NREQ-1:0]  req_a,
  input  logic [8*NREQ-1:0]  req_b,
  input  logic [8*NREQ-1:0]  req_op,
  output logic [DW-1:0]      alu_a,
  output logic [DW-1:0]      alu_b,
  output logic [DW-1:0]      alu_op,
  input  logic [DW-1:0]      alu_z,
  input  logic [DW-1:0]      alu_flags,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_z,
  output logic [DW-1:0]      rsp_flags,
  output logic [DW-1:0]      err_cnt
);

  localparam int unsigned SW = IDW + 1;

  state_e         state_q;
  state_e         state_d;
  logic [IDW-1:0] rr_ptr;
  logic [7:0]     valid_pad;
  logic [IDW-1:0] cand;
  logic           grant_any;
  logic [IDW-1:0] grant_idx;
  logic [NREQ-1:0] grant_oh;
  alu_req_t       grant_req;
  logic           accept;
  logic           exec;
  logic           retire;
  logic [IDW-1:0] next_ptr;

  // (base + k) mod NREQ without a divider
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int unsigned k);
    logic [SW-1:0] sum;
    sum = {1'b0, base} + SW'(k);
    if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
    return sum[IDW-1:0];
  endfunction

  assign valid_pad = 8'(req_valid);

  // Scan requesters starting at rr_ptr; first pending one wins
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = wrap_add(rr_ptr, k);
      if (!grant_any && valid_pad[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Winner one-hot and its operand slice
  always_comb begin
    grant_oh  = '0;
    grant_req = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_any && (grant_idx == IDW'(i))) begin
        grant_oh[i]  = 1'b1;
        grant_req.a  = req_a[i*8 +: 8];
        grant_req.b  = req_b[i*8 +: 8];
        grant_req.op = req_op[i*8 +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (grant_any) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; req_ready is held low while reset is asserted
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    exec      = 1'b0;
    retire    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        accept = grant_any;
        if (rst_n) req_ready = grant_oh;
      end
      ST_EXEC: exec = 1'b1;
      ST_RESP: retire = rsp_ready;
      default: ;
    endcase
  end

  assign next_ptr = (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + IDW'(1);

  // Operand, response and fault-count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_id    <= '0;
      rsp_z     <= '0;
      rsp_flags <= '0;
      rsp_valid <= 1'b0;
      err_cnt   <= '0;
      rr_ptr    <= '0;
    end else begin
      if (accept) begin
        alu_a  <= grant_req.a;
        alu_b  <= grant_req.b;
        alu_op <= grant_req.op;
        rsp_id <= grant_idx;
      end
      if (exec) begin
        rsp_z     <= alu_z;
        rsp_flags <= alu_flags;
        rsp_valid <= 1'b1;
        if (alu_flags[FLAG_UNKNOWN] && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      end
      if (retire) begin
        rsp_valid <= 1'b0;
        rr_ptr    <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU plus transaction-level arbitration model.
module tb_alu_arbiter;
  localparam int NREQ = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a, req_b, req_op;
  logic [7:0]        alu_a, alu_b, alu_op, alu_z, alu_flags;
  logic              rsp_valid, rsp_ready;
  logic [2:0]        rsp_id;
  logic [7:0]        rsp_z, rsp_flags, err_cnt;

  logic [7:0] ta [NREQ];
  logic [7:0] tbv[NREQ];
  logic [7:0] top[NREQ];

  int errors, checks, cyc;
  int model_ptr, model_err;
  logic [7:0] last_a;

  alu_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_z(alu_z), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_flags(rsp_flags),
    .err_cnt(err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: {flags, z}
  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    logic [7:0] z, f;
    logic [8:0] s;
    logic [15:0] p;
    logic gt, eq;
    z = 8'd0; f = 8'd0; s = 9'd0; p = 16'd0;
    gt = (a > b); eq = (a == b);
    case (op[4:0])
      5'd0: begin s = {1'b0, a} + {1'b0, b}; z = s[7:0]; f[0] = s[8]; end
      5'd1: begin z = a - b; f[1] = (a < b); end
      5'd2: begin p = 16'(a) * 16'(b); z = p[7:0]; f[0] = (p[15:8] != 8'd0); end
      5'd3: if (b == 8'd0) f[4] = 1'b1; else z = a / b;
      5'd4: begin
        f[2] = gt; f[3] = eq;
        case (op[7:5])
          3'd0: z = 8'(!gt && !eq);
          3'd1: z = 8'(!gt);
          3'd2: z = 8'(gt);
          3'd3: z = 8'(gt || eq);
          3'd4: z = 8'(eq);
          3'd5: z = 8'(!eq);
          3'd6: z = 8'd0;
          default: z = 8'd1;
        endcase
      end
      5'd5: z = a & b;
      5'd6: z = a | b;
      5'd7: z = a ^ b;
      5'd8: for (int i = 0; i < 8; i++) if (b[i]) z = z ^ 8'(a << i);
      default: f[5] = 1'b1;
    endcase
    return {f, z};
  endfunction

  always_comb {alu_flags, alu_z} = alu_ref(alu_a, alu_b, alu_op);

  always_comb begin
    req_a = '0; req_b = '0; req_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*8 +: 8]  = ta[i];
      req_b[i*8 +: 8]  = tbv[i];
      req_op[i*8 +: 8] = top[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] mask);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [7:0] rand_op();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 9) return 8'h1F;
    return {3'($urandom_range(0, 7)), 5'(r)};
  endfunction

  task automatic scramble();
    for (int i = 0; i < NREQ; i++) begin
      ta[i] = 8'($urandom); tbv[i] = 8'($urandom); top[i] = rand_op();
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One full transaction from IDLE; hold = extra RESP cycles with rsp_ready low
  task automatic serve(input logic [NREQ-1:0] mask, input int hold, output int g, output int gcyc);
    logic [15:0] r;
    logic [7:0]  ea, eb, eop;
    rsp_ready = 1'b0;
    req_valid = mask;
    #1;
    g = model_grant(mask);
    gcyc = cyc;
    if (g < 0) begin
      chk("serve_no_grant", 32'(req_ready), 32'd0);
      return;
    end
    chk("grant_ready", 32'(req_ready), 32'(1) << g);
    ea = ta[g]; eb = tbv[g]; eop = top[g];
    r = alu_ref(ea, eb, eop);
    if (r[13] && model_err < 255) model_err++;
    step();
    scramble();
    rsp_ready = 1'b1;
    #1;
    chk("exec_ready", 32'(req_ready), 32'd0);
    chk("exec_valid", 32'(rsp_valid), 32'd0);
    chk("exec_alu_a", 32'(alu_a), 32'(ea));
    chk("exec_alu_b", 32'(alu_b), 32'(eb));
    chk("exec_alu_op", 32'(alu_op), 32'(eop));
    step();
    for (int h = 0; h <= hold; h++) begin
      rsp_ready = (h == hold);
      #1;
      chk("resp_valid", 32'(rsp_valid), 32'd1);
      chk("resp_id", 32'(rsp_id), 32'(g));
      chk("resp_z", 32'(rsp_z), 32'(r[7:0]));
      chk("resp_flags", 32'(rsp_flags), 32'(r[15:8]));
      chk("resp_err_cnt", 32'(err_cnt), 32'(model_err));
      chk("resp_ready_low", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b0;
    model_ptr = (g + 1) % NREQ;
    last_a = ea;
    chk("retire_valid", 32'(rsp_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    model_ptr = 0;
    model_err = 0;
    last_a = 8'd0;
  endtask

  int g, gc, prev_gc;

  initial begin
    errors = 0; checks = 0; cyc = 0;
    model_ptr = 0; model_err = 0; last_a = 8'd0;
    rst_n = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    scramble();
    #1 rst_n = 1'b0;
    req_valid = '1;
    #1;
    // Reset state, with all requests pending
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_z", 32'(rsp_z), 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    do_reset();

    // Basic add with overflow
    ta[0] = 8'd200; tbv[0] = 8'd100; top[0] = 8'h00;
    serve(4'b0001, 0, g, gc);
    req_valid = '0;
    chk("add_id", 32'(rsp_id), 32'd0);
    chk("add_z", 32'(rsp_z), 32'd44);
    chk("add_flags", 32'(rsp_flags), 32'h01);

    // Divide by zero
    ta[2] = 8'd9; tbv[2] = 8'd0; top[2] = 8'h03;
    serve(4'b0100, 0, g, gc);
    req_valid = '0;
    chk("div0_id", 32'(rsp_id), 32'd2);
    chk("div0_z", 32'(rsp_z), 32'd0);
    chk("div0_flags", 32'(rsp_flags), 32'h10);

    // Unknown opcode: fault counter saturates
    for (int n = 0; n < 257; n++) begin
      ta[3] = 8'($urandom); tbv[3] = 8'($urandom); top[3] = 8'h1F;
      serve(4'b1000, 0, g, gc);
      chk("unk_flags", 32'(rsp_flags), 32'h20);
    end
    req_valid = '0;
    chk("unk_err_sat", 32'(err_cnt), 32'd255);

    // Contention from reset: 0,1,0,1 three cycles apart
    do_reset();
    prev_gc = 0;
    for (int k = 0; k < 4; k++) begin
      serve(4'b0011, 0, g, gc);
      chk("cont_grant", 32'(g), 32'(k % 2));
      if (k > 0) chk("cont_spacing", 32'(gc - prev_gc), 32'd3);
      prev_gc = gc;
    end

    // Backpressure with req1 pending, then req1 wins right after retire
    serve(4'b0011, 5, g, gc);
    chk("bp_first", 32'(g), 32'd0);
    prev_gc = gc;
    serve(4'b0011, 0, g, gc);
    chk("bp_second", 32'(g), 32'd1);
    chk("bp_spacing", 32'(gc - prev_gc), 32'd8);
    req_valid = '0;

    // Reset during EXEC of a compare drops the op
    ta[0] = 8'd5; tbv[0] = 8'd5; top[0] = 8'h84;
    req_valid = 4'b0001;
    #1;
    chk("mid_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("mid_alu_a", 32'(alu_a), 32'd0);
    chk("mid_alu_op", 32'(alu_op), 32'd0);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rsp_z", 32'(rsp_z), 32'd0);
    chk("mid_err_cnt", 32'(err_cnt), 32'd0);
    step();
    rst_n = 1'b1;
    model_ptr = 0; model_err = 0; last_a = 8'd0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
      chk("mid_no_ready", 32'(req_ready), 32'd0);
    end
    ta[0] = 8'd5; tbv[0] = 8'd5; top[0] = 8'h84;
    serve(4'b0001, 0, g, gc);
    req_valid = '0;
    chk("mid_retry_z", 32'(rsp_z), 32'd1);
    chk("mid_retry_flags", 32'(rsp_flags), 32'h08);

    // Randomized traffic against the model
    for (int t = 0; t < 150; t++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom);
      if (m == '0) begin
        req_valid = '0;
        #1;
        chk("rnd_idle_ready", 32'(req_ready), 32'd0);
        step();
        chk("rnd_idle_valid", 32'(rsp_valid), 32'd0);
        chk("rnd_idle_alu_a", 32'(alu_a), 32'(last_a));
      end else begin
        serve(m, $urandom_range(0, 2), g, gc);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
